clk_divider: RTL and testbench

- Synchronous integer clock divider producing a divided clock from one input clock.
- Used to derive slow clocks from a system clock or PLL, e.g. the DAC polling clock (N=8 from 25 MHz gives 3.125 MHz) and the ADC sample clock (N=4 from 200 MHz gives 50 MHz).
- Outputs come straight from flops, so they are glitch-free.
- Also emits a one-cycle enable tick aligned to the divided clock's rising edge, for logic that stays in the clk_in domain.

---
 rtl/clk_divider.sv | 63 ++++++
 tb/tb_clk_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// Integer clock divider: free-running phase counter with registered divided
// clock and a one-cycle tick coincident with each divided-clock rising edge.
module clk_divider #(
  parameter int N = 2
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_div,
  output logic tick
);

  localparam int CNT_W   = (N < 2) ? 1 : $clog2(N);
  localparam int LOW_LEN = (N + 1) / 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOW_CNT  = CNT_W'(LOW_LEN);

  generate
    if (N < 2) begin : g_bad_n
      $error("clk_divider: N must be an integer >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_div_q;
  logic             clk_div_d;
  logic             tick_q;
  logic             tick_d;

  // Next phase and next output values, all derived from the upcoming count.
  always_comb begin
    cnt_d     = CNT_ZERO;
    clk_div_d = 1'b0;
    tick_d    = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    clk_div_d = (cnt_d >= LOW_CNT);
    tick_d    = (cnt_d == LOW_CNT);
  end

  // Counter and output flops; reset forces all of them low immediately.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q     <= CNT_ZERO;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_div = clk_div_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: several ratios side by side, checked every cycle
// against an edge-count model, plus literal pins and an async mid-period reset.
module tb_clk_divider;

  localparam int NI = 7;

  function automatic int n_of(input int i);
    case (i)
      0:       n_of = 2;
      1:       n_of = 3;
      2:       n_of = 4;
      3:       n_of = 5;
      4:       n_of = 6;
      5:       n_of = 8;
      default: n_of = 10;
    endcase
  endfunction

  logic clk;
  logic rst;
  logic div_w  [NI];
  logic tick_w [NI];
  int   cnt_w  [NI];

  int n_checks;
  int n_err;
  int k;
  logic prev_tick [NI];
  int   tick_cnt  [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      clk_divider #(.N(n_of(g))) u_dut (
        .clk_in  (clk),
        .rst     (rst),
        .clk_div (div_w[g]),
        .tick    (tick_w[g])
      );
      assign cnt_w[g] = int'(u_dut.cnt_q);
    end
  endgenerate

  task automatic check(input string name, input int g, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s N=%0d k=%0d t=%0t: got %0d expected %0d",
               name, n_of(g), k, $time, act, exp);
    end
  endtask

  // Reference: k edges since release puts the phase at k mod N.
  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      int nn;
      int ph;
      int ed;
      int et;
      nn = n_of(g);
      ph = k % nn;
      ed = (rst == 1'b1) ? 0 : ((ph >= (nn + 1) / 2) ? 1 : 0);
      et = (rst == 1'b1) ? 0 : ((ph == (nn + 1) / 2) ? 1 : 0);
      check("clk_div", g, int'(div_w[g]), ed);
      check("tick", g, int'(tick_w[g]), et);
      check("tick_not_back_to_back", g, int'(prev_tick[g] & tick_w[g]), 0);
      check("cnt_below_n", g, (cnt_w[g] < nn) ? 1 : 0, 1);
      prev_tick[g] = tick_w[g];
      if (tick_w[g]) tick_cnt[g]++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) k++;
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_counts();
    for (int g = 0; g < NI; g++) tick_cnt[g] = 0;
  endtask

  int pat8  [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  int tk8   [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  int pat4  [4] = '{0, 1, 1, 0};

  task automatic pin_literals();
    if (k >= 1 && k <= 8) begin
      check("n8_lit_div", 5, int'(div_w[5]), pat8[k-1]);
      check("n8_lit_tick", 5, int'(tick_w[5]), tk8[k-1]);
    end
    if (k >= 1 && k <= 4) begin
      check("n4_lit_div", 2, int'(div_w[2]), pat4[k-1]);
    end
    if (k >= 1 && k <= 6) begin
      check("n2_lit_div", 0, int'(div_w[0]), k % 2);
      check("n2_tick_eq_div", 0, int'(tick_w[0]), int'(div_w[0]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    k        = 0;
    rst      = 1'b1;
    for (int g = 0; g < NI; g++) prev_tick[g] = 1'b0;
    clear_counts();

    cycle();
    cycle();
    rst = 1'b0;
    clear_counts();

    for (int i = 0; i < 64; i++) begin
      cycle();
      pin_literals();
      if (k == 50) begin
        check("n5_ticks_50", 3, tick_cnt[3], 10);
      end
    end
    check("n8_ticks_64", 5, tick_cnt[5], 8);
    check("n4_ticks_64", 2, tick_cnt[2], 16);
    check("n2_ticks_64", 0, tick_cnt[0], 32);

    // Advance to N=8 phase 5, then reset between edges.
    for (int i = 0; i < 16 && (k % 8) != 5; i++) cycle();
    check("n8_at_phase5", 5, k % 8, 5);
    check("n8_high_before_rst", 5, int'(div_w[5]), 1);
    #2;
    rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      check("async_rst_div", g, int'(div_w[g]), 0);
      check("async_rst_tick", g, int'(tick_w[g]), 0);
      check("async_rst_cnt", g, cnt_w[g], 0);
    end
    k = 0;
    cycle();
    cycle();
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      cycle();
      pin_literals();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
